// File: rtl/midi_sysid_read_arbiter.sv
// Round-robin read arbiter sharing the single-word system-ID slave between
// the host bridge (requester 0) and the MIDI self-test engine (requester 1).
// Each grant drives the slave for one ACCESS cycle, captures the word into
// the winner's data register and pulses that requester's rvalid for one
// cycle. Address-0 reads also update sticky ID match/mismatch flags.

module midi_sysid_read_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] slave_readdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    // Capture slave data on this port's grant; rvalid trails capture by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= capture;
            if (capture)
                rdata <= slave_readdata;
        end
    end

endmodule

module midi_sysid_read_arbiter #(
    parameter int                   DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] EXPECTED_ID = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  addr0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  addr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid1,
    output logic                  slave_address,
    input  logic [DATA_WIDTH-1:0] slave_readdata,
    output logic                  busy,
    output logic                  id_ok,
    output logic                  id_bad
);

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state;
    logic   ptr;        // requester favoured when both request
    logic   win;        // latched winner index
    logic   lat_addr;   // latched winner address
    logic   win_next;
    logic   id_match;

    logic [NUM_REQ-1:0]                 capture_vec;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_vec;
    logic [NUM_REQ-1:0]                 rvalid_vec;

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign win_next = req1 & (~req0 | ptr);
    assign id_match = (slave_readdata == EXPECTED_ID);

    // Control FSM; all outputs it drives are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            win           <= 1'b0;
            lat_addr      <= 1'b0;
            slave_address <= 1'b0;
            busy          <= 1'b0;
            id_ok         <= 1'b0;
            id_bad        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        win           <= win_next;
                        lat_addr      <= win_next ? addr1 : addr0;
                        slave_address <= win_next ? addr1 : addr0;
                        busy          <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    slave_address <= 1'b0;
                    if (!lat_addr) begin
                        id_ok  <= id_match;
                        id_bad <= !id_match;
                    end
                    state <= RESPOND;
                end
                RESPOND: begin
                    ptr   <= ~win;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    slave_address <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // One data/valid register pair per requester; only the winner captures.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        assign capture_vec[i] = (state == ACCESS) && (win == 1'(i));

        midi_sysid_read_port #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_port (
            .clock          (clock),
            .reset          (reset),
            .capture        (capture_vec[i]),
            .slave_readdata (slave_readdata),
            .rdata          (rdata_vec[i]),
            .rvalid         (rvalid_vec[i])
        );
    end

    assign rdata0  = rdata_vec[0];
    assign rdata1  = rdata_vec[1];
    assign rvalid0 = rvalid_vec[0];
    assign rvalid1 = rvalid_vec[1];

endmodule

// File: tb/tb_midi_sysid_read_arbiter.sv
// Directed bench for midi_sysid_read_arbiter: single reads, ID status,
// round-robin contention, dropped requests and reset mid-access.

module tb_midi_sysid_read_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, addr0 = 1'b0, req1 = 1'b0, addr1 = 1'b0;
    logic [31:0] rdata0, rdata1, slave_readdata = '0;
    logic        rvalid0, rvalid1, slave_address, busy, id_ok, id_bad;

    int n_tests = 0;
    int n_fail  = 0;

    midi_sysid_read_arbiter #(
        .DATA_WIDTH  (32),
        .EXPECTED_ID (32'h0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req0           (req0),
        .addr0          (addr0),
        .rdata0         (rdata0),
        .rvalid0        (rvalid0),
        .req1           (req1),
        .addr1          (addr1),
        .rdata1         (rdata1),
        .rvalid1        (rvalid1),
        .slave_address  (slave_address),
        .slave_readdata (slave_readdata),
        .busy           (busy),
        .id_ok          (id_ok),
        .id_bad         (id_bad)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset and idle
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_outs", {rvalid0, rvalid1, busy, slave_address, id_ok, id_bad}, 64'h0);
        end
        chk("idle_rdata0", rdata0, 64'h0);
        chk("idle_rdata1", rdata1, 64'h0);

        // Requester 0 timestamp read
        req0 = 1'b1; addr0 = 1'b1; slave_readdata = 32'h54EC4B2D;
        tick();
        chk("r0_access_addr", slave_address, 64'h1);
        chk("r0_access_busy", busy, 64'h1);
        chk("r0_access_rvalid", {rvalid0, rvalid1}, 64'h0);
        tick();
        chk("r0_rvalid", {rvalid0, rvalid1}, 64'h2);
        chk("r0_rdata", rdata0, 64'h54EC4B2D);
        chk("r0_flags", {id_ok, id_bad}, 64'h0);
        chk("r0_respond_addr", slave_address, 64'h0);
        chk("r0_respond_busy", busy, 64'h1);
        req0 = 1'b0;
        tick();
        chk("r0_back_idle", {rvalid0, rvalid1, busy}, 64'h0);

        // Requester 1 ID read, matching
        req1 = 1'b1; addr1 = 1'b0; slave_readdata = 32'h0;
        tick();
        chk("id_match_addr", slave_address, 64'h0);
        tick();
        chk("id_match_rvalid", {rvalid0, rvalid1}, 64'h1);
        chk("id_match_rdata1", rdata1, 64'h0);
        chk("id_match_flags", {id_ok, id_bad}, 64'h2);
        chk("id_match_rdata0_kept", rdata0, 64'h54EC4B2D);
        req1 = 1'b0;
        tick();

        // Requester 1 ID read, mismatching
        req1 = 1'b1; slave_readdata = 32'h1;
        tick();
        tick();
        chk("id_bad_rvalid", {rvalid0, rvalid1}, 64'h1);
        chk("id_bad_rdata1", rdata1, 64'h1);
        chk("id_bad_flags", {id_ok, id_bad}, 64'h1);
        req1 = 1'b0;
        tick();

        // Address-1 read leaves flags alone; addr change after grant ignored
        req0 = 1'b1; addr0 = 1'b1; slave_readdata = 32'h0;
        tick();
        addr0 = 1'b0;
        chk("addr_latch_access", slave_address, 64'h1);
        tick();
        chk("addr_latch_rvalid", rvalid0, 64'h1);
        chk("addr1_flags_kept", {id_ok, id_bad}, 64'h1);
        req0 = 1'b0;
        tick();

        // Contention from reset release: order 0,1,0,1
        reset = 1'b1;
        tick();
        chk("reset_flags", {id_ok, id_bad}, 64'h0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 1'b1; addr1 = 1'b1; slave_readdata = 32'hA0;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rr_rvalid0", rvalid0, ((k == 2) || (k == 8)) ? 64'h1 : 64'h0);
            chk("rr_rvalid1", rvalid1, ((k == 5) || (k == 11)) ? 64'h1 : 64'h0);
        end
        chk("rr_rdata0", rdata0, 64'hA0);
        chk("rr_rdata1", rdata1, 64'hA0);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("rr_idle", busy, 64'h0);

        // Requester 0 pulse drops before sampling; only requester 1 served
        req0 = 1'b1; req1 = 1'b1; addr1 = 1'b1; slave_readdata = 32'h12345678;
        #2;
        req0 = 1'b0;
        tick();
        tick();
        chk("drop_rvalid", {rvalid0, rvalid1}, 64'h1);
        chk("drop_rdata1", rdata1, 64'h12345678);
        chk("drop_rdata0_kept", rdata0, 64'hA0);
        req1 = 1'b0;
        tick();

        // Requester 0 ID read so the pointer ends up favouring requester 1
        req0 = 1'b1; addr0 = 1'b0; slave_readdata = 32'h0;
        tick();
        tick();
        chk("pre_rst_rvalid", rvalid0, 64'h1);
        chk("pre_rst_flags", {id_ok, id_bad}, 64'h2);
        req0 = 1'b0;
        tick();

        // Reset during ACCESS of a requester 1 read
        req1 = 1'b1; addr1 = 1'b0; slave_readdata = 32'hFF;
        tick();
        chk("mid_rst_busy", busy, 64'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {rvalid0, rvalid1, busy, slave_address, id_ok, id_bad}, 64'h0);
        tick();
        chk("mid_rst_no_rvalid", {rvalid0, rvalid1}, 64'h0);
        req0 = 1'b1; addr0 = 1'b1; req1 = 1'b1; slave_readdata = 32'hCAFE;
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_winner", {rvalid0, rvalid1}, 64'h2);
        chk("post_rst_rdata0", rdata0, 64'hCAFE);
        chk("post_rst_rdata1", rdata1, 64'h0);
        chk("post_rst_flags", {id_ok, id_bad}, 64'h0);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
